// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM capture block.
// Optional glitch filter in the input path: define PWM_CAPTURE_FILTER_EN.
package pwm_pkg;

   // Width of all counters and measurement outputs.
   localparam int CNT_W = 32;

   // Cycles without a rising edge before the input is declared stuck.
   localparam int TIMEOUT_DEF = 5000;

   // Counter terminal value of the board PWM generator (period = value + 1).
   localparam int GEN_PERIOD = 2500;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      STUCK = 2'd3
   } state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input conditioning for pwm_capture: 2-FF synchroniser, optional glitch
// filter (PWM_CAPTURE_FILTER_EN) and rise/fall pulse generation.
// Without the filter, rise/fall are seen by the consumer 3 cycles after pwm_in.
module pwm_edge_sync #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;
   logic       cur;

   // Shift the asynchronous input through the two synchroniser stages.
   always_comb begin
      sync_d = {sync_q[0], pwm_in};
   end

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic             filt_q, filt_d;
   logic [RUN_W-1:0] run_q, run_d;

   // Accept a new level only after it has been stable for FILTER_LEN samples.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      filt_d = filt_q;
      run_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (run_q == RUN_W'(FILTER_LEN - 1)) begin
            filt_d = sync_q[1];
         end else begin
            run_d = run_q + 1'b1;
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt_q <= 1'b0;
         run_q  <= '0;
      end else begin
         filt_q <= filt_d;
         run_q  <= run_d;
      end
   end

   assign cur = filt_q;
`else
   logic unused_filter_len;
   assign unused_filter_len = (FILTER_LEN > 0);
   assign cur = sync_q[1];
`endif

   // Previous sample of the conditioned level, for edge detection.
   always_comb begin
      prev_d = cur;
   end

   // Synchroniser and previous-sample registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = cur;
   assign rise  = cur & ~prev_q;
   assign fall  = ~cur & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period (rise to rise) and high time (rise to fall)
// of pwm_in in clk cycles, with a one-cycle valid per completed period and
// a stuck-line timeout. Optional input glitch filter: PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
   parameter int CNT_W      = pwm_pkg::CNT_W,
   parameter int TIMEOUT    = pwm_pkg::TIMEOUT_DEF,
   parameter int FILTER_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             valid,
   output logic             stuck,
   output logic             level
);

   import pwm_pkg::*;

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic rise, fall;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [CNT_W-1:0] period_out_q, period_out_d;
   logic [CNT_W-1:0] high_out_q, high_out_d;
   logic             valid_q, valid_d;
   logic             stuck_q, stuck_d;

   pwm_edge_sync #(
      .FILTER_LEN (FILTER_LEN)
   ) u_edge_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   // Next-state logic for the measurement FSM, counters and output registers.
   always_comb begin
      state_d      = state_q;
      period_cnt_d = period_cnt_q;
      high_cnt_d   = high_cnt_q;
      idle_cnt_d   = idle_cnt_q;
      period_out_d = period_out_q;
      high_out_d   = high_out_q;
      valid_d      = 1'b0;
      stuck_d      = stuck_q;

      if (!enable) begin
         state_d      = IDLE;
         period_cnt_d = '0;
         high_cnt_d   = '0;
         idle_cnt_d   = '0;
         period_out_d = '0;
         high_out_d   = '0;
         stuck_d      = 1'b0;
      end else begin
         unique case (state_q)
            // No edge seen yet: the first rise only starts a measurement.
            IDLE: begin
               if (rise) begin
                  state_d      = HIGH;
                  period_cnt_d = ONE;
                  high_cnt_d   = ONE;
                  idle_cnt_d   = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
                  if (idle_cnt_d == TMO) begin
                     state_d      = STUCK;
                     stuck_d      = 1'b1;
                     period_out_d = '0;
                     high_out_d   = '0;
                  end
               end
            end

            // Timing out exactly at TMO keeps the counters from ever passing it.
            HIGH: begin
               if (period_cnt_q == TMO) begin
                  state_d      = STUCK;
                  stuck_d      = 1'b1;
                  period_out_d = '0;
                  high_out_d   = '0;
               end else begin
                  period_cnt_d = period_cnt_q + 1'b1;
                  if (fall) begin
                     state_d = LOW;
                  end else begin
                     high_cnt_d = high_cnt_q + 1'b1;
                  end
               end
            end

            // A rise closes the period; it takes priority over the timeout.
            LOW: begin
               if (rise) begin
                  state_d      = HIGH;
                  period_out_d = period_cnt_q;
                  high_out_d   = high_cnt_q;
                  valid_d      = 1'b1;
                  period_cnt_d = ONE;
                  high_cnt_d   = ONE;
               end else if (period_cnt_q == TMO) begin
                  state_d      = STUCK;
                  stuck_d      = 1'b1;
                  period_out_d = '0;
                  high_out_d   = '0;
               end else begin
                  period_cnt_d = period_cnt_q + 1'b1;
               end
            end

            // Line stuck: resume measuring at the next rise, no valid for it.
            STUCK: begin
               if (rise) begin
                  state_d      = HIGH;
                  stuck_d      = 1'b0;
                  period_cnt_d = ONE;
                  high_cnt_d   = ONE;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         period_cnt_q <= '0;
         high_cnt_q   <= '0;
         idle_cnt_q   <= '0;
         period_out_q <= '0;
         high_out_q   <= '0;
         valid_q      <= 1'b0;
         stuck_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_cnt_q <= period_cnt_d;
         high_cnt_q   <= high_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         period_out_q <= period_out_d;
         high_out_q   <= high_out_d;
         valid_q      <= valid_d;
         stuck_q      <= stuck_d;
      end
   end

   assign period_out = period_out_q;
   assign high_out   = high_out_q;
   assign valid      = valid_q;
   assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture. Expected measurements come from a
// waveform model fed with the driven samples; they are queued at each modelled
// rise and compared when the DUT raises valid.
module tb_pwm_capture;

   import pwm_pkg::*;

   localparam int TMO  = TIMEOUT_DEF;
   localparam int FLEN = 4;
`ifdef PWM_CAPTURE_FILTER_EN
   localparam int LAT = 3 + FLEN;
`else
   localparam int LAT = 3;
`endif

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b0;
   logic             enable = 1'b0;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             valid;
   logic             stuck;
   logic             level;

   pwm_capture #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TMO),
      .FILTER_LEN (FLEN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .pwm_in     (pwm_in),
      .period_out (period_out),
      .high_out   (high_out),
      .valid      (valid),
      .stuck      (stuck),
      .level      (level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] p;
      logic [31:0] h;
   } meas_t;

   meas_t exp_q[$];
   meas_t mon_m;
   int    checks = 0;
   int    errors = 0;

   // waveform model state
   int cyc       = 0;
   bit armed     = 1'b0;
   int last_rise = 0;
   int last_fall = 0;
   bit mlvl      = 1'b0;
   int mrun      = 0;
   int c         = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit v);
      bit nl;
`ifdef PWM_CAPTURE_FILTER_EN
      nl = mlvl;
      if (v != mlvl) begin
         mrun++;
         if (mrun == FLEN) begin
            nl   = v;
            mrun = 0;
         end
      end else begin
         mrun = 0;
      end
`else
      nl = v;
`endif
      if (nl && !mlvl) begin
         if (armed) exp_q.push_back('{p: 32'(cyc - last_rise), h: 32'(last_fall - last_rise)});
         armed     = 1'b1;
         last_rise = cyc;
      end
      if (!nl && mlvl) last_fall = cyc;
      mlvl = nl;
   endtask

   task automatic drive(input bit v);
      pwm_in = v;
      @(posedge clk);
      #1;
      cyc++;
      model_step(v);
   endtask

   task automatic wave(input int h, input int l, input int n);
      repeat (n) begin
         repeat (h) drive(1'b1);
         repeat (l) drive(1'b0);
      end
   endtask

   // Scoreboard: every valid must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && valid) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_valid observed period %0d high %0d expected none", period_out, high_out);
         end
         if (exp_q.size() > 0) begin
            mon_m = exp_q.pop_front();
            check("valid_period", period_out, mon_m.p);
            check("valid_high", high_out, mon_m.h);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) drive(1'b0);
      check("rst_period", period_out, 0);
      check("rst_high", high_out, 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_stuck", 32'(stuck), 0);
      check("rst_level", 32'(level), 0);
      rst_n = 1'b1;
      repeat (4) drive(1'b0);
      enable = 1'b1;

      // high 3 / low 5: no valid on the first rise, then 8/3
      wave(3, 5, 6);

      // generator loop-back: counter 0..GEN_PERIOD, high while count < 1000
      wave(1000, GEN_PERIOD + 1 - 1000, 4);
      check("loop_period", period_out, GEN_PERIOD + 1);
      check("loop_high", high_out, 1000);

      // input held high: stuck after TIMEOUT cycles from the detected rise
      c = 0;
      for (int i = 1; i <= TMO + 100; i++) begin
         drive(1'b1);
         if (stuck === 1'b1) begin
            c = i;
            break;
         end
      end
      check("stuck_hi_time", c, TMO + LAT);
      check("stuck_hi_level", 32'(level), 1);
      check("stuck_hi_period", period_out, 0);
      check("stuck_hi_high", high_out, 0);
      armed = 1'b0;
      repeat (10) drive(1'b0);
      check("stuck_after_fall", 32'(stuck), 1);

      // disable clears; then input held low from enable
      enable = 1'b0;
      repeat (2) drive(1'b0);
      check("dis_stuck", 32'(stuck), 0);
      check("dis_period", period_out, 0);
      enable = 1'b1;
      c = 0;
      for (int i = 1; i <= TMO + 100; i++) begin
         drive(1'b0);
         if (stuck === 1'b1) begin
            c = i;
            break;
         end
      end
      check("stuck_lo_time", c, TMO);
      check("stuck_lo_period", period_out, 0);
      check("stuck_lo_high", high_out, 0);
      repeat (10) drive(1'b1);
      check("stuck_clear_on_rise", 32'(stuck), 0);
      repeat (10) drive(1'b0);
      wave(10, 10, 3);
      check("recover_period", period_out, 20);
      check("recover_high", high_out, 10);

      // reset for one cycle in the middle of a high phase
      repeat (10) drive(1'b1);
      rst_n = 1'b0;
      drive(1'b0);
      rst_n = 1'b1;
      armed = 1'b0;
      mlvl  = 1'b0;
      mrun  = 0;
      check("midrst_period", period_out, 0);
      check("midrst_high", high_out, 0);
      check("midrst_valid", 32'(valid), 0);
      check("midrst_stuck", 32'(stuck), 0);
      check("midrst_level", 32'(level), 0);
      repeat (5) drive(1'b0);
      wave(3, 5, 4);

      // enable dropped for one cycle in the middle of a low phase
      wave(4, 6, 2);
      repeat (3) drive(1'b0);
      enable = 1'b0;
      drive(1'b0);
      enable = 1'b1;
      armed = 1'b0;
      check("middis_period", period_out, 0);
      check("middis_high", high_out, 0);
      check("middis_valid", 32'(valid), 0);
      check("middis_level", 32'(level), 0);
      wave(6, 4, 4);

      // 2-cycle glitch inside a 100/400 waveform
      repeat (4) begin
         repeat (100) drive(1'b1);
         repeat (150) drive(1'b0);
         repeat (2) drive(1'b1);
         repeat (148) drive(1'b0);
      end
      repeat (LAT + 5) drive(1'b0);
`ifdef PWM_CAPTURE_FILTER_EN
      check("glitch_period", period_out, 400);
`else
      check("glitch_period", period_out, 250);
`endif
      check("glitch_high", high_out, 100);

      check("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
